remote_load_resp_unit: RTL and testbench



---
 rtl/remote_load_resp_unit_if.sv | 59 +++++
 rtl/remote_load_resp_unit.sv | 134 +++++++++++++
 tb/tb_remote_load_resp_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/remote_load_resp_unit_if.sv
// Load-info typedef and the handshake/bus bundle between network RX, the core and the response unit.
// master = surrounding core/network side, slave = remote_load_resp_unit.
package remote_load_resp_unit_pkg;
  localparam int rv32_reg_addr_width_gp = 5;

  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;
endpackage

interface remote_load_resp_unit_if #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int cnt_width_p      = 6
);
  import remote_load_resp_unit_pkg::*;

  logic                        resp_v_i;
  logic [data_width_p-1:0]     resp_data_i;
  load_info_s                  resp_load_info_i;
  logic [reg_addr_width_p-1:0] resp_reg_id_i;
  logic                        resp_yumi_o;

  logic                        int_wb_v_o;
  logic                        int_wb_yumi_i;
  logic                        float_wb_v_o;
  logic                        float_wb_yumi_i;
  logic                        icache_v_o;
  logic                        icache_yumi_i;
  logic [reg_addr_width_p-1:0] wb_reg_id_o;
  logic [data_width_p-1:0]     wb_data_o;
  logic [data_width_p-1:0]     icache_data_o;

  logic                        req_sent_i;
  logic                        credit_avail_o;
  logic [cnt_width_p-1:0]      outstanding_o;
  logic                        err_o;

  modport master (
    output resp_v_i, resp_data_i, resp_load_info_i, resp_reg_id_i,
    output int_wb_yumi_i, float_wb_yumi_i, icache_yumi_i, req_sent_i,
    input  resp_yumi_o, int_wb_v_o, float_wb_v_o, icache_v_o,
    input  wb_reg_id_o, wb_data_o, icache_data_o,
    input  credit_avail_o, outstanding_o, err_o
  );

  modport slave (
    input  resp_v_i, resp_data_i, resp_load_info_i, resp_reg_id_i,
    input  int_wb_yumi_i, float_wb_yumi_i, icache_yumi_i, req_sent_i,
    output resp_yumi_o, int_wb_v_o, float_wb_v_o, icache_v_o,
    output wb_reg_id_o, wb_data_o, icache_data_o,
    output credit_avail_o, outstanding_o, err_o
  );
endinterface

// File: rtl/remote_load_resp_unit.sv
// Remote load responses -> 2-entry FIFO -> aligned int/float/icache writeback, plus outstanding-load credit counter.
// Latency 1 cycle; with REMOTE_LOAD_RESP_BYPASS_EN an empty FIFO presents the response in the same cycle.
// Backpressure: resp_yumi_o drops while the FIFO is full; a head waits until its selected port yumis.
module remote_load_resp_unit
  import remote_load_resp_unit_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int max_out_p    = 32
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  remote_load_resp_unit_if.slave bus
);

  localparam int reg_addr_width_lp = rv32_reg_addr_width_gp;
  localparam int cnt_width_lp      = $clog2(max_out_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_out_p);

  typedef struct packed {
    logic [data_width_p-1:0]      data;
    load_info_s                   info;
    logic [reg_addr_width_lp-1:0] reg_id;
  } entry_s;

  entry_s     mem [2];
  entry_s     in_entry;
  entry_s     head;
  logic       rd_ptr, wr_ptr;
  logic [1:0] used;
  logic       empty, full;
  logic       head_v;
  logic       enq, deq, fifo_deq, bad_yumi;
  logic       sel_int, sel_float, sel_icache;

  logic [cnt_width_lp-1:0] cnt;
  logic                    err;

  logic [7:0]              byte_lane;
  logic [15:0]             hex_lane;
  logic [data_width_p-1:0] aligned;

  assign in_entry = '{bus.resp_data_i, bus.resp_load_info_i, bus.resp_reg_id_i};
  assign empty    = (used == 2'd0);
  assign full     = (used == 2'd2);

  // A slot freed by a dequeue is only reusable next cycle, so acceptance looks at registered fullness.
  assign bus.resp_yumi_o = bus.resp_v_i & ~full;

`ifdef REMOTE_LOAD_RESP_BYPASS_EN
  logic bypass;
  assign bypass   = empty & bus.resp_v_i;
  assign head     = bypass ? in_entry : mem[rd_ptr];
  assign head_v   = ~empty | bus.resp_v_i;
  assign enq      = bus.resp_v_i & ~full & ~(bypass & deq);
  assign fifo_deq = deq & ~bypass;
`else
  assign head     = mem[rd_ptr];
  assign head_v   = ~empty;
  assign enq      = bus.resp_v_i & ~full;
  assign fifo_deq = deq;
`endif

  // icache refills take priority over the float flag; int is the fallback.
  assign sel_icache = head_v & head.info.icache_fetch;
  assign sel_float  = head_v & ~head.info.icache_fetch & head.info.float_wb;
  assign sel_int    = head_v & ~head.info.icache_fetch & ~head.info.float_wb;

  assign deq = (sel_icache & bus.icache_yumi_i)
             | (sel_float  & bus.float_wb_yumi_i)
             | (sel_int    & bus.int_wb_yumi_i);

  assign bad_yumi = (~sel_icache & bus.icache_yumi_i)
                  | (~sel_float  & bus.float_wb_yumi_i)
                  | (~sel_int    & bus.int_wb_yumi_i);

  always_comb begin
    byte_lane = head.data[{head.info.part_sel, 3'b000} +: 8];
    hex_lane  = head.info.part_sel[1] ? head.data[31:16] : head.data[15:0];
    aligned   = head.data;
    if (head.info.is_byte_op) begin
      aligned = {{(data_width_p-8){~head.info.is_unsigned_op & byte_lane[7]}}, byte_lane};
    end else if (head.info.is_hex_op) begin
      aligned = {{(data_width_p-16){~head.info.is_unsigned_op & hex_lane[15]}}, hex_lane};
    end
  end

  assign bus.int_wb_v_o     = sel_int;
  assign bus.float_wb_v_o   = sel_float;
  assign bus.icache_v_o     = sel_icache;
  assign bus.wb_reg_id_o    = head_v ? head.reg_id : '0;
  assign bus.wb_data_o      = head_v ? aligned : '0;
  assign bus.icache_data_o  = head_v ? head.data : '0;
  assign bus.credit_avail_o = (cnt < max_cnt_lp);
  assign bus.outstanding_o  = cnt;
  assign bus.err_o          = err;

  // Storage is not reset: outputs are gated by head_v, so stale words never escape.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      used   <= 2'd0;
    end else begin
      if (enq)      wr_ptr <= ~wr_ptr;
      if (fifo_deq) rd_ptr <= ~rd_ptr;
      case ({enq, fifo_deq})
        2'b10:   used <= used + 2'd1;
        2'b01:   used <= used - 2'd1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (bus.req_sent_i & ~deq) begin
        if (cnt == max_cnt_lp) err <= 1'b1;
        else                   cnt <= cnt + cnt_width_lp'(1);
      end else if (~bus.req_sent_i & deq) begin
        if (cnt == '0) err <= 1'b1;
        else           cnt <= cnt - cnt_width_lp'(1);
      end
      if (bad_yumi) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_remote_load_resp_unit.sv
// Directed bench for remote_load_resp_unit: table-driven alignment/routing vectors plus multi-cycle corner cases.
module tb_remote_load_resp_unit;
  import remote_load_resp_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  remote_load_resp_unit_if #(.data_width_p(32), .reg_addr_width_p(5), .cnt_width_p(6)) bus();

  remote_load_resp_unit #(.data_width_p(32), .max_out_p(32)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    load_info_s  info;
    logic [4:0]  reg_id;
    logic [2:0]  exp_v;   // {icache, float, int}
    logic [31:0] exp_wb;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic load_info_s li(input logic fw, input logic ic, input logic un,
                                    input logic by, input logic hx, input logic [1:0] ps);
    load_info_s r;
    r.float_wb       = fw;
    r.icache_fetch   = ic;
    r.is_unsigned_op = un;
    r.is_byte_op     = by;
    r.is_hex_op      = hx;
    r.part_sel       = ps;
    return r;
  endfunction

  function automatic logic [31:0] valids();
    return {29'd0, bus.icache_v_o, bus.float_wb_v_o, bus.int_wb_v_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.resp_v_i         = 1'b0;
    bus.resp_data_i      = '0;
    bus.resp_load_info_i = '0;
    bus.resp_reg_id_i    = '0;
    bus.int_wb_yumi_i    = 1'b0;
    bus.float_wb_yumi_i  = 1'b0;
    bus.icache_yumi_i    = 1'b0;
    bus.req_sent_i       = 1'b0;
  endtask

  task automatic drive(input logic [31:0] d, input load_info_s inf, input logic [4:0] r);
    bus.resp_v_i         = 1'b1;
    bus.resp_data_i      = d;
    bus.resp_load_info_i = inf;
    bus.resp_reg_id_i    = r;
  endtask

  task automatic pulse_req(input int n);
    for (int k = 0; k < n; k++) begin
      bus.req_sent_i = 1'b1;
      tick();
    end
    bus.req_sent_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{32'h8000_00F0, li(0,0,0,1,0,2'd0), 5'd5,  3'b001, 32'hFFFF_FFF0};
    vecs[1] = '{32'hBEEF_1234, li(1,0,1,0,1,2'd2), 5'd7,  3'b010, 32'h0000_BEEF};
    vecs[2] = '{32'h0000_0013, li(1,1,0,0,0,2'd0), 5'd0,  3'b100, 32'h0000_0013};
    vecs[3] = '{32'h9A00_0000, li(0,0,1,1,0,2'd3), 5'd31, 3'b001, 32'h0000_009A};
    vecs[4] = '{32'h0080_0000, li(0,0,0,1,0,2'd2), 5'd1,  3'b001, 32'hFFFF_FF80};
    vecs[5] = '{32'h1234_8001, li(0,0,0,0,1,2'd0), 5'd2,  3'b001, 32'hFFFF_8001};
    vecs[6] = '{32'h7FFF_0000, li(1,0,0,0,1,2'd2), 5'd3,  3'b010, 32'h0000_7FFF};
    vecs[7] = '{32'hDEAD_BEEF, li(1,0,0,0,0,2'd1), 5'd4,  3'b010, 32'hDEAD_BEEF};
    vecs[8] = '{32'h0000_7F00, li(0,0,0,1,0,2'd1), 5'd9,  3'b001, 32'h0000_007F};

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", valids(), 32'd0);
    chk("rst_resp_yumi", {31'd0, bus.resp_yumi_o}, 32'd0);
    chk("rst_credit", {31'd0, bus.credit_avail_o}, 32'd1);
    chk("rst_outstanding", {26'd0, bus.outstanding_o}, 32'd0);
    chk("rst_err", {31'd0, bus.err_o}, 32'd0);
    chk("rst_wb_data", bus.wb_data_o, 32'd0);
    chk("rst_icache_data", bus.icache_data_o, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      bus.req_sent_i = 1'b1;
      drive(vecs[i].data, vecs[i].info, vecs[i].reg_id);
      #1;
      chk($sformatf("v%0d_accept", i), {31'd0, bus.resp_yumi_o}, 32'd1);
      tick();
      bus.resp_v_i   = 1'b0;
      bus.req_sent_i = 1'b0;
      #1;
      chk($sformatf("v%0d_route", i), valids(), {29'd0, vecs[i].exp_v});
      chk($sformatf("v%0d_wb_data", i), bus.wb_data_o, vecs[i].exp_wb);
      chk($sformatf("v%0d_icache_data", i), bus.icache_data_o, vecs[i].data);
      chk($sformatf("v%0d_reg_id", i), {27'd0, bus.wb_reg_id_o}, {27'd0, vecs[i].reg_id});
      chk($sformatf("v%0d_out_pending", i), {26'd0, bus.outstanding_o}, 32'd1);
      bus.int_wb_yumi_i   = vecs[i].exp_v[0];
      bus.float_wb_yumi_i = vecs[i].exp_v[1];
      bus.icache_yumi_i   = vecs[i].exp_v[2];
      tick();
      bus.int_wb_yumi_i   = 1'b0;
      bus.float_wb_yumi_i = 1'b0;
      bus.icache_yumi_i   = 1'b0;
      #1;
      chk($sformatf("v%0d_drained", i), valids(), 32'd0);
      chk($sformatf("v%0d_out_done", i), {26'd0, bus.outstanding_o}, 32'd0);
    end
    chk("vec_err", {31'd0, bus.err_o}, 32'd0);

    // Full FIFO: third response must wait, order preserved.
    pulse_req(3);
    drive(32'h0000_000A, li(0,0,0,0,0,2'd0), 5'd10);
    #1 chk("full_acc_a", {31'd0, bus.resp_yumi_o}, 32'd1);
    tick();
    drive(32'h0000_000B, li(0,0,0,0,0,2'd0), 5'd11);
    #1 chk("full_acc_b", {31'd0, bus.resp_yumi_o}, 32'd1);
    tick();
    drive(32'h0000_000C, li(0,0,0,0,0,2'd0), 5'd12);
    #1 chk("full_block_c", {31'd0, bus.resp_yumi_o}, 32'd0);
    chk("full_head_a", bus.wb_data_o, 32'h0000_000A);
    tick();
    bus.int_wb_yumi_i = 1'b1;
    #1 chk("full_no_refill", {31'd0, bus.resp_yumi_o}, 32'd0);
    tick();
    bus.int_wb_yumi_i = 1'b0;
    #1 chk("full_acc_c", {31'd0, bus.resp_yumi_o}, 32'd1);
    chk("full_head_b", bus.wb_data_o, 32'h0000_000B);
    chk("full_reg_b", {27'd0, bus.wb_reg_id_o}, 32'd11);
    tick();
    bus.resp_v_i = 1'b0;
    bus.int_wb_yumi_i = 1'b1;
    #1 chk("full_head_b2", bus.wb_data_o, 32'h0000_000B);
    tick();
    chk("full_head_c", bus.wb_data_o, 32'h0000_000C);
    tick();
    bus.int_wb_yumi_i = 1'b0;
    #1 chk("full_empty", valids(), 32'd0);
    chk("full_out", {26'd0, bus.outstanding_o}, 32'd0);
    chk("full_err", {31'd0, bus.err_o}, 32'd0);

    // Credit counter saturation and simultaneous inc/dec.
    pulse_req(31);
    #1 chk("cnt31_credit", {31'd0, bus.credit_avail_o}, 32'd1);
    chk("cnt31_out", {26'd0, bus.outstanding_o}, 32'd31);
    pulse_req(1);
    #1 chk("cnt32_credit", {31'd0, bus.credit_avail_o}, 32'd0);
    chk("cnt32_out", {26'd0, bus.outstanding_o}, 32'd32);
    chk("cnt32_err", {31'd0, bus.err_o}, 32'd0);
    pulse_req(1);
    #1 chk("cnt33_err", {31'd0, bus.err_o}, 32'd1);
    chk("cnt33_out", {26'd0, bus.outstanding_o}, 32'd32);
    drive(32'h1111_2222, li(0,0,0,0,0,2'd0), 5'd6);
    tick();
    bus.resp_v_i = 1'b0;
    bus.int_wb_yumi_i = 1'b1;
    bus.req_sent_i = 1'b1;
    tick();
    idle();
    #1 chk("incdec_out", {26'd0, bus.outstanding_o}, 32'd32);
    chk("incdec_drained", valids(), 32'd0);

    // Reset mid-operation drops buffered data.
    drive(32'h5555_AAAA, li(0,0,0,0,0,2'd0), 5'd8);
    tick();
    bus.resp_v_i = 1'b0;
    #1 chk("midrst_pre_v", valids(), 32'd1);
    reset_n = 1'b0;
    #1 chk("midrst_v", valids(), 32'd0);
    chk("midrst_out", {26'd0, bus.outstanding_o}, 32'd0);
    chk("midrst_err", {31'd0, bus.err_o}, 32'd0);
    chk("midrst_credit", {31'd0, bus.credit_avail_o}, 32'd1);
    chk("midrst_data", bus.wb_data_o, 32'd0);
    reset_n = 1'b1;
    tick();

    // Dequeue with zero outstanding saturates and flags.
    drive(32'h0000_0001, li(0,0,0,0,0,2'd0), 5'd1);
    tick();
    bus.resp_v_i = 1'b0;
    bus.int_wb_yumi_i = 1'b1;
    tick();
    bus.int_wb_yumi_i = 1'b0;
    #1 chk("under_out", {26'd0, bus.outstanding_o}, 32'd0);
    chk("under_err", {31'd0, bus.err_o}, 32'd1);

    // Yumi on an unselected port is ignored and flags.
    do_reset();
    chk("bad_pre_err", {31'd0, bus.err_o}, 32'd0);
    drive(32'h0000_0002, li(0,0,0,0,0,2'd0), 5'd2);
    tick();
    bus.resp_v_i = 1'b0;
    bus.float_wb_yumi_i = 1'b1;
    tick();
    bus.float_wb_yumi_i = 1'b0;
    #1 chk("bad_err", {31'd0, bus.err_o}, 32'd1);
    chk("bad_kept", valids(), 32'd1);
    chk("bad_kept_data", bus.wb_data_o, 32'h0000_0002);

    // Latency of an empty-FIFO response.
    do_reset();
    pulse_req(1);
`ifdef REMOTE_LOAD_RESP_BYPASS_EN
    drive(32'h0000_00FF, li(0,0,0,1,0,2'd0), 5'd3);
    bus.int_wb_yumi_i = 1'b1;
    #1 chk("lat_same_v", valids(), 32'd1);
    chk("lat_same_data", bus.wb_data_o, 32'hFFFF_FFFF);
    chk("lat_same_yumi", {31'd0, bus.resp_yumi_o}, 32'd1);
    tick();
    idle();
    #1 chk("lat_empty", valids(), 32'd0);
`else
    drive(32'h0000_00FF, li(0,0,0,1,0,2'd0), 5'd3);
    #1 chk("lat_same_v", valids(), 32'd0);
    tick();
    bus.resp_v_i = 1'b0;
    #1 chk("lat_next_v", valids(), 32'd1);
    chk("lat_next_data", bus.wb_data_o, 32'hFFFF_FFFF);
    bus.int_wb_yumi_i = 1'b1;
    tick();
    idle();
    #1 chk("lat_empty", valids(), 32'd0);
`endif
    chk("lat_out", {26'd0, bus.outstanding_o}, 32'd0);
    chk("lat_err", {31'd0, bus.err_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
